// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage with IF/ID register, stall/flush/redirect, and the HALT drain FSM.
// Define IF_INST_COUNT_EN to add the o_inst_count fetched-instruction counter.
module instruction_fetch_stage #(
  parameter int NB_PC        = 32,
  parameter int NB_INST      = 32,
  parameter int NB_OP        = 6,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_redirect,
  input  logic [NB_PC-1:0]   i_redirect_pc,
  output logic [NB_PC-1:0]   o_imem_addr,
  input  logic [NB_INST-1:0] i_imem_data,
  output logic [NB_INST-1:0] o_inst,
  output logic [NB_PC-1:0]   o_pc_plus4,
  output logic               o_inst_valid,
  output logic               o_halted
`ifdef IF_INST_COUNT_EN
  ,
  output logic [31:0]        o_inst_count
`endif
);

  localparam int NB_CNT = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]         r_state;
  logic [NB_CNT-1:0]  r_drain_cnt;
  logic [NB_PC-1:0]   r_pc;
  logic [NB_INST-1:0] r_inst;
  logic [NB_PC-1:0]   r_pc_plus4;
  logic               r_inst_valid;
  logic               r_halted;

  logic [NB_PC-1:0]   w_pc_plus4;
  logic [NB_PC-1:0]   w_pc_next_run;
  logic               w_is_halt;
  logic               w_load;
  logic               w_flush_run;

  // Adder width matches NB_PC so the PC wraps naturally at the top of memory.
  assign w_pc_plus4    = r_pc + NB_PC'(4);
  assign w_pc_next_run = i_redirect ? i_redirect_pc : w_pc_plus4;

  assign w_is_halt = (i_imem_data[31:26] == {NB_OP{1'b0}}) &&
                     (i_imem_data[NB_OP-1:0] == {NB_OP{1'b1}});

  assign w_load      = (r_state == ST_RUN) && !i_stall && !i_flush;
  assign w_flush_run = (r_state == ST_RUN) && !i_stall &&  i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_RUN;
      r_drain_cnt  <= '0;
      r_pc         <= '0;
      r_inst       <= '0;
      r_pc_plus4   <= '0;
      r_inst_valid <= 1'b0;
      r_halted     <= 1'b0;
    end else if (i_enable) begin
      case (r_state)
        ST_RUN: begin
          if (w_flush_run) begin
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_pc_plus4   <= w_pc_plus4;
            r_pc         <= w_pc_next_run;
          end else if (w_load) begin
            r_inst       <= i_imem_data;
            r_inst_valid <= 1'b1;
            r_pc_plus4   <= w_pc_plus4;
            // A HALT freezes the PC just past itself regardless of redirect.
            if (w_is_halt) begin
              r_pc        <= w_pc_plus4;
              r_state     <= ST_DRAIN;
              r_drain_cnt <= NB_CNT'(DRAIN_CYCLES);
            end else begin
              r_pc        <= w_pc_next_run;
            end
          end
        end
        ST_DRAIN: begin
          r_inst       <= '0;
          r_inst_valid <= 1'b0;
          if (r_drain_cnt <= NB_CNT'(1)) begin
            r_drain_cnt <= '0;
            r_state     <= ST_HALTED;
            r_halted    <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - NB_CNT'(1);
          end
        end
        ST_HALTED: begin
          r_inst       <= '0;
          r_inst_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef IF_INST_COUNT_EN
  logic [31:0] r_inst_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inst_count <= '0;
    end else if (i_enable && w_load && (r_inst_count != 32'hFFFF_FFFF)) begin
      r_inst_count <= r_inst_count + 32'd1;
    end
  end

  assign o_inst_count = r_inst_count;
`endif

  assign o_imem_addr  = r_pc;
  assign o_inst       = r_inst;
  assign o_pc_plus4   = r_pc_plus4;
  assign o_inst_valid = r_inst_valid;
  assign o_halted     = r_halted;

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Feeds the opcode/function fields consumed by the ID-stage control unit.
- Owns the PC, the instruction-memory address, and the IF/ID latch with stall/flush/bubble handling.
- Runs a HALT drain state machine that tells the debug unit when the pipeline has emptied after a HALT instruction.

Parameters:
- NB_PC, 32, PC / instruction-memory byte-address width
- NB_INST, 32, instruction width
- NB_OP, 6, opcode and function field width
- DRAIN_CYCLES, 4, enabled cycles after HALT leaves IF/ID before o_halted asserts (ID, EX, MEM, WB)

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_enable  in  1  debug-unit run/step gate; 0 freezes all state
- i_stall  in  1  hazard-unit stall; hold PC and IF/ID
- i_flush  in  1  branch/jump taken in ID; squash the instruction being fetched
- i_redirect  in  1  load PC from i_redirect_pc
- i_redirect_pc  in  NB_PC  branch/jump/JR target
- o_imem_addr  out  NB_PC  current PC to instruction memory (combinational read)
- i_imem_data  in  NB_INST  instruction at o_imem_addr, same cycle
- o_inst  out  NB_INST  IF/ID instruction to decode; opcode [31:26], function [5:0]
- o_pc_plus4  out  NB_PC  IF/ID PC+4 for JAL/JALR link and branch offset
- o_inst_valid  out  1  IF/ID holds a real instruction; 0 means bubble
- o_halted  out  1  pipeline drained after HALT; sticky until reset

Behaviour:
Reset values (async, i_rst=1):
- PC=0, o_inst=0 (NOP), o_pc_plus4=0, o_inst_valid=0, o_halted=0, state=RUN, drain counter=0.

Enable gate:
- No state changes while i_enable=0, including the drain counter.
- o_imem_addr=PC is always combinational.

Update priority in RUN on an enabled cycle:
1. i_stall=1: PC and IF/ID hold. i_flush and i_redirect are ignored; the hazard unit re-presents them.
2. i_flush=1: IF/ID <= {inst=0, valid=0, pc_plus4=PC+4}. PC <= i_redirect_pc if i_redirect, else PC+4.
3. Otherwise: IF/ID <= {i_imem_data, PC+4, valid=1}. PC <= i_redirect_pc if i_redirect, else PC+4.

Arithmetic:
- PC+4 is modulo 2^NB_PC; 0xFFFFFFFC wraps to 0.
- i_redirect_pc is used as given; the low 2 bits are not checked.

HALT detect:
- Condition: case 3 loads an instruction with opcode=000000 and function=111111.
- Transition RUN->DRAIN. The HALT word itself is latched into IF/ID with valid=1.
- The PC freezes at HALT address+4.
- A HALT squashed by i_flush is not detected.

DRAIN state (enabled cycles only):
- IF/ID <= NOP, valid=0.
- PC held; i_stall, i_flush and i_redirect are ignored.
- Counter loads DRAIN_CYCLES on entry and decrements each enabled cycle.
- When the counter reaches 0: go to HALTED.

HALTED state:
- o_halted=1. PC and IF/ID frozen (NOP, valid=0).
- Exit only via i_rst.

Other rules:
- Reset mid-DRAIN or mid-stall returns everything to the reset values immediately.
- Outputs o_inst, o_pc_plus4, o_inst_valid and o_halted are registered; no combinational input-to-output paths except o_imem_addr.

Optional Feature:
- Macro IF_INST_COUNT_EN.
- When defined: adds output port o_inst_count (32 bits). It is reset to 0 and increments on every case-3 load (HALT included), saturating at 0xFFFFFFFF. The debug unit reports it.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset release, enable=1, imem returns ADDU words -> o_imem_addr 0,4,8,12 on successive cycles; o_pc_plus4 4,8,12 lags one cycle; o_inst_valid=1 from the first edge.
2. i_stall=1 for 2 cycles at PC=8 -> o_imem_addr stays 8 and IF/ID holds the PC=4 instruction; resume gives 12.
3. At PC=16, i_flush=1 and i_redirect=1 with i_redirect_pc=0x40 -> next cycle o_inst=0, o_inst_valid=0, o_imem_addr=0x40; the following cycle fetches 0x40.
4. HALT (0x0000003F) at address 0x20 -> IF/ID holds 0x0000003F with valid=1, then NOPs; PC stays 0x24; o_halted=1 exactly 4 enabled cycles after the HALT load; it stays 1 until i_rst.
5. i_enable=0 for 3 cycles during DRAIN -> counter frozen and o_halted is delayed by 3 cycles; i_rst pulse mid-DRAIN -> PC=0, o_halted=0.
6. HALT fetched in the same cycle as i_flush=1 -> not detected, state stays RUN, fetch continues at the redirect target. With IF_INST_COUNT_EN defined, o_inst_count excludes the squashed word.
